// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register bank, tracks in-flight writes in a scoreboard,
// and stalls decode on RAW/WAW hazards. Define OPERAND_FETCH_BYPASS_EN to forward writeback data.
module operand_fetch #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dec_valid_i,
    output logic            dec_ready_o,
    input  logic [AW-1:0]   dec_rs1_i,
    input  logic [AW-1:0]   dec_rs2_i,
    input  logic            dec_use_rs1_i,
    input  logic            dec_use_rs2_i,
    input  logic [AW-1:0]   dec_rd_i,
    input  logic            dec_rd_wr_i,
    output logic [AW-1:0]   rf_rs1_addr_o,
    output logic [AW-1:0]   rf_rs2_addr_o,
    input  logic [XLEN-1:0] rf_rs1_data_i,
    input  logic [XLEN-1:0] rf_rs2_data_i,
    input  logic            wb_en_i,
    input  logic [AW-1:0]   wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output logic [XLEN-1:0] ex_rs1_o,
    output logic [XLEN-1:0] ex_rs2_o,
    output logic [AW-1:0]   ex_rd_o,
    output logic            ex_rd_wr_o,
    output logic            busy_o
);

    localparam int DEPTH = 1 << AW;

`ifdef OPERAND_FETCH_BYPASS_EN
    localparam logic BYPASS_EN = 1'b1;
`else
    localparam logic BYPASS_EN = 1'b0;
`endif

    // Returns {ready, operand} for one source register.
    function automatic logic [XLEN:0] select_src(
        input logic            use_src,
        input logic [AW-1:0]   addr,
        input logic [XLEN-1:0] rf_data,
        input logic            pend,
        input logic            wb_en,
        input logic [AW-1:0]   wb_addr,
        input logic [XLEN-1:0] wb_data
    );
        logic [XLEN:0] res;
        if (!use_src || (addr == {AW{1'b0}})) begin
            res = {1'b1, {XLEN{1'b0}}};
        end else if (BYPASS_EN && wb_en && (wb_addr == addr)) begin
            res = {1'b1, wb_data};
        end else begin
            res = {~pend, rf_data};
        end
        return res;
    endfunction

    logic [DEPTH-1:0] pending_r;
    logic [DEPTH-1:0] pending_set_s;
    logic [DEPTH-1:0] pending_clr_s;
    logic [DEPTH-1:0] pending_nxt_s;

    logic             ex_valid_r;
    logic [XLEN-1:0]  ex_rs1_r;
    logic [XLEN-1:0]  ex_rs2_r;
    logic [AW-1:0]    ex_rd_r;
    logic             ex_rd_wr_r;

    logic [XLEN:0]    src1_s;
    logic [XLEN:0]    src2_s;
    logic             waw_s;
    logic             hazard_s;
    logic             slot_free_s;
    logic             dec_ready_s;
    logic             accept_s;
    logic             rd_tracked_s;
    logic             wb_clear_s;

    assign rf_rs1_addr_o = dec_rs1_i;
    assign rf_rs2_addr_o = dec_rs2_i;

    // Source readiness and operand selection.
    always_comb begin
        src1_s = select_src(dec_use_rs1_i, dec_rs1_i, rf_rs1_data_i, pending_r[dec_rs1_i],
                            wb_en_i, wb_addr_i, wb_data_i);
        src2_s = select_src(dec_use_rs2_i, dec_rs2_i, rf_rs2_data_i, pending_r[dec_rs2_i],
                            wb_en_i, wb_addr_i, wb_data_i);
    end

    // Hazard detection and handshake; a writeback to rd in this cycle lifts the WAW stall.
    always_comb begin
        rd_tracked_s = dec_rd_wr_i && (dec_rd_i != {AW{1'b0}});
        waw_s        = rd_tracked_s && pending_r[dec_rd_i] &&
                       !(wb_en_i && (wb_addr_i == dec_rd_i));
        hazard_s     = !src1_s[XLEN] || !src2_s[XLEN] || waw_s;
        slot_free_s  = !ex_valid_r || ex_ready_i;
        dec_ready_s  = slot_free_s && !hazard_s;
        accept_s     = dec_valid_i && dec_ready_s;
    end

    // Scoreboard next state; a set in the same cycle as a clear of the same index wins.
    always_comb begin
        wb_clear_s = wb_en_i && (wb_addr_i != {AW{1'b0}});
        if (wb_clear_s) begin
            pending_clr_s = {{(DEPTH-1){1'b0}}, 1'b1} << wb_addr_i;
        end else begin
            pending_clr_s = {DEPTH{1'b0}};
        end
        if (accept_s && rd_tracked_s) begin
            pending_set_s = {{(DEPTH-1){1'b0}}, 1'b1} << dec_rd_i;
        end else begin
            pending_set_s = {DEPTH{1'b0}};
        end
        pending_nxt_s = (pending_r & ~pending_clr_s) | pending_set_s;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= {DEPTH{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    // Execute-stage pipeline register; holds its contents while execute is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_r <= 1'b0;
            ex_rs1_r   <= {XLEN{1'b0}};
            ex_rs2_r   <= {XLEN{1'b0}};
            ex_rd_r    <= {AW{1'b0}};
            ex_rd_wr_r <= 1'b0;
        end else if (accept_s) begin
            ex_valid_r <= 1'b1;
            ex_rs1_r   <= src1_s[XLEN-1:0];
            ex_rs2_r   <= src2_s[XLEN-1:0];
            ex_rd_r    <= dec_rd_i;
            ex_rd_wr_r <= dec_rd_wr_i;
        end else if (ex_ready_i) begin
            ex_valid_r <= 1'b0;
        end else begin
            ex_valid_r <= ex_valid_r;
        end
    end

    assign dec_ready_o = dec_ready_s;
    assign ex_valid_o  = ex_valid_r;
    assign ex_rs1_o    = ex_rs1_r;
    assign ex_rs2_o    = ex_rs2_r;
    assign ex_rd_o     = ex_rd_r;
    assign ex_rd_wr_o  = ex_rd_wr_r;
    assign busy_o      = |pending_r;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized traffic
// checked against a queue-based model of in-flight destination writes.
module tb_operand_fetch;

    localparam int XLEN = 32;
    localparam int AW   = 5;

`ifdef OPERAND_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            dec_valid_i, dec_ready_o;
    logic [AW-1:0]   dec_rs1_i, dec_rs2_i, dec_rd_i;
    logic            dec_use_rs1_i, dec_use_rs2_i, dec_rd_wr_i;
    logic [AW-1:0]   rf_rs1_addr_o, rf_rs2_addr_o;
    logic [XLEN-1:0] rf_rs1_data_i, rf_rs2_data_i;
    logic            wb_en_i;
    logic [AW-1:0]   wb_addr_i;
    logic [XLEN-1:0] wb_data_i;
    logic            ex_valid_o, ex_ready_i;
    logic [XLEN-1:0] ex_rs1_o, ex_rs2_o;
    logic [AW-1:0]   ex_rd_o;
    logic            ex_rd_wr_o, busy_o;

    int total = 0;
    int bad   = 0;

    logic [XLEN-1:0] bank [32];
    logic [AW-1:0]   inflight [$];
    bit              m_valid;
    logic [XLEN-1:0] m_rs1, m_rs2;
    logic [AW-1:0]   m_rd;
    bit              m_rdwr;

    operand_fetch #(.XLEN(XLEN), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
        .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i),
        .dec_use_rs1_i(dec_use_rs1_i), .dec_use_rs2_i(dec_use_rs2_i),
        .dec_rd_i(dec_rd_i), .dec_rd_wr_i(dec_rd_wr_i),
        .rf_rs1_addr_o(rf_rs1_addr_o), .rf_rs2_addr_o(rf_rs2_addr_o),
        .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
        .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o),
        .ex_rd_o(ex_rd_o), .ex_rd_wr_o(ex_rd_wr_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Register bank: x0 returns garbage that the stage must ignore.
    assign rf_rs1_data_i = (rf_rs1_addr_o == 5'd0) ? 32'hDEAD_BEEF : bank[rf_rs1_addr_o];
    assign rf_rs2_data_i = (rf_rs2_addr_o == 5'd0) ? 32'hDEAD_BEEF : bank[rf_rs2_addr_o];
    always @(posedge clk) if (wb_en_i && wb_addr_i != 5'd0) bank[wb_addr_i] <= wb_data_i;

    function automatic bit is_pending(logic [AW-1:0] a);
        foreach (inflight[i]) if (inflight[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: {ready, operand} for one source from the architectural rules.
    function automatic logic [XLEN:0] ref_src(bit u, logic [AW-1:0] s);
        if (!u || s == 5'd0) return {1'b1, 32'd0};
        if (BYP && wb_en_i && wb_addr_i == s) return {1'b1, wb_data_i};
        return {!is_pending(s), bank[s]};
    endfunction

    task automatic idle_inputs();
        dec_valid_i = 1'b0; dec_rs1_i = 5'd0; dec_rs2_i = 5'd0;
        dec_use_rs1_i = 1'b0; dec_use_rs2_i = 1'b0; dec_rd_i = 5'd0; dec_rd_wr_i = 1'b0;
        wb_en_i = 1'b0; wb_addr_i = 5'd0; wb_data_i = 32'd0; ex_ready_i = 1'b1;
    endtask

    task automatic drive(logic [AW-1:0] rs1, logic [AW-1:0] rs2, bit u1, bit u2,
                         logic [AW-1:0] rd, bit wr);
        dec_valid_i = 1'b1; dec_rs1_i = rs1; dec_rs2_i = rs2;
        dec_use_rs1_i = u1; dec_use_rs2_i = u2; dec_rd_i = rd; dec_rd_wr_i = wr;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        inflight.delete();
        m_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic bank_write(logic [AW-1:0] a, logic [XLEN-1:0] d);
        wb_en_i = 1'b1; wb_addr_i = a; wb_data_i = d;
        @(posedge clk); #1;
        wb_en_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst_n = 1'b0;
        #1;
        total += 6;
        if (ex_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", ex_valid_o); end
        if (ex_rs1_o !== 32'd0) begin bad++; $display("FAIL reset_rs1: got %h want 0", ex_rs1_o); end
        if (ex_rs2_o !== 32'd0) begin bad++; $display("FAIL reset_rs2: got %h want 0", ex_rs2_o); end
        if (ex_rd_o !== 5'd0) begin bad++; $display("FAIL reset_rd: got %0d want 0", ex_rd_o); end
        if (ex_rd_wr_o !== 1'b0) begin bad++; $display("FAIL reset_rdwr: got %0b want 0", ex_rd_wr_o); end
        if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i < 32; i++) bank_write(i[4:0], $urandom);
    endtask

    task automatic test_basic();
        bank_write(5'd3, 32'd7);
        bank_write(5'd4, 32'd9);
        drive(5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1);
        #1;
        total++;
        if (dec_ready_o !== 1'b1) begin bad++; $display("FAIL basic_ready: got %0b want 1", dec_ready_o); end
        @(posedge clk); #1;
        dec_valid_i = 1'b0;
        total += 6;
        if (ex_valid_o !== 1'b1) begin bad++; $display("FAIL basic_valid: got %0b want 1", ex_valid_o); end
        if (ex_rs1_o !== 32'd7) begin bad++; $display("FAIL basic_rs1: got %h want 7", ex_rs1_o); end
        if (ex_rs2_o !== 32'd9) begin bad++; $display("FAIL basic_rs2: got %h want 9", ex_rs2_o); end
        if (ex_rd_o !== 5'd5) begin bad++; $display("FAIL basic_rd: got %0d want 5", ex_rd_o); end
        if (ex_rd_wr_o !== 1'b1) begin bad++; $display("FAIL basic_rdwr: got %0b want 1", ex_rd_wr_o); end
        if (busy_o !== 1'b1) begin bad++; $display("FAIL basic_busy: got %0b want 1", busy_o); end
    endtask

    task automatic test_raw();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        repeat (2) begin
            #1;
            total++;
            if (dec_ready_o !== 1'b0) begin bad++; $display("FAIL raw_stall: got %0b want 0", dec_ready_o); end
            @(posedge clk); #1;
        end
        wb_en_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'h1234;
        #1;
        total++;
`ifdef OPERAND_FETCH_BYPASS_EN
        if (dec_ready_o !== 1'b1) begin bad++; $display("FAIL raw_wb_cycle: got %0b want 1", dec_ready_o); end
        @(posedge clk); #1;
        wb_en_i = 1'b0;
`else
        if (dec_ready_o !== 1'b0) begin bad++; $display("FAIL raw_wb_cycle: got %0b want 0", dec_ready_o); end
        @(posedge clk); #1;
        wb_en_i = 1'b0;
        #1;
        total++;
        if (dec_ready_o !== 1'b1) begin bad++; $display("FAIL raw_after_wb: got %0b want 1", dec_ready_o); end
        @(posedge clk); #1;
`endif
        dec_valid_i = 1'b0;
        total += 4;
        if (ex_valid_o !== 1'b1) begin bad++; $display("FAIL raw_valid: got %0b want 1", ex_valid_o); end
        if (ex_rs1_o !== 32'h1234) begin bad++; $display("FAIL raw_rs1: got %h want 1234", ex_rs1_o); end
        if (ex_rs2_o !== 32'd0) begin bad++; $display("FAIL raw_rs2_unused: got %h want 0", ex_rs2_o); end
        if (busy_o !== 1'b0) begin bad++; $display("FAIL raw_busy: got %0b want 0", busy_o); end
    endtask

    task automatic test_x0();
        apply_reset();
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1);
        #1;
        total++;
        if (dec_ready_o !== 1'b1) begin bad++; $display("FAIL x0_ready: got %0b want 1", dec_ready_o); end
        @(posedge clk); #1;
        dec_valid_i = 1'b0;
        total += 4;
        if (ex_valid_o !== 1'b1) begin bad++; $display("FAIL x0_valid: got %0b want 1", ex_valid_o); end
        if (ex_rs1_o !== 32'd0) begin bad++; $display("FAIL x0_rs1: got %h want 0", ex_rs1_o); end
        if (ex_rs2_o !== 32'd0) begin bad++; $display("FAIL x0_rs2: got %h want 0", ex_rs2_o); end
        if (busy_o !== 1'b0) begin bad++; $display("FAIL x0_busy: got %0b want 0", busy_o); end
    endtask

    task automatic test_backpressure();
        logic [XLEN-1:0] a1, a2;
        apply_reset();
        a1 = bank[1]; a2 = bank[2];
        drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1);
        @(posedge clk); #1;
        drive(5'd3, 5'd4, 1'b1, 1'b1, 5'd11, 1'b1);
        ex_ready_i = 1'b0;
        wb_en_i = 1'b1; wb_addr_i = 5'd1; wb_data_i = ~a1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (dec_ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d]: got %0b want 0", i, dec_ready_o); end
            @(posedge clk); #1;
            wb_en_i = 1'b0;
            total += 4;
            if (ex_valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, ex_valid_o); end
            if (ex_rs1_o !== a1) begin bad++; $display("FAIL bp_rs1[%0d]: got %h want %h", i, ex_rs1_o, a1); end
            if (ex_rs2_o !== a2) begin bad++; $display("FAIL bp_rs2[%0d]: got %h want %h", i, ex_rs2_o, a2); end
            if (ex_rd_o !== 5'd10) begin bad++; $display("FAIL bp_rd[%0d]: got %0d want 10", i, ex_rd_o); end
        end
        ex_ready_i = 1'b1;
        #1;
        total++;
        if (dec_ready_o !== 1'b1) begin bad++; $display("FAIL bp_release: got %0b want 1", dec_ready_o); end
        @(posedge clk); #1;
        dec_valid_i = 1'b0;
        total += 3;
        if (ex_rs1_o !== 32'd7) begin bad++; $display("FAIL bp_new_rs1: got %h want 7", ex_rs1_o); end
        if (ex_rs2_o !== 32'd9) begin bad++; $display("FAIL bp_new_rs2: got %h want 9", ex_rs2_o); end
        if (ex_rd_o !== 5'd11) begin bad++; $display("FAIL bp_new_rd: got %0d want 11", ex_rd_o); end
    endtask

    task automatic test_collision();
        apply_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1);
        @(posedge clk); #1;
        wb_en_i = 1'b1; wb_addr_i = 5'd6; wb_data_i = 32'h66;
        #1;
        total++;
        if (dec_ready_o !== 1'b1) begin bad++; $display("FAIL coll_waw_cleared: got %0b want 1", dec_ready_o); end
        @(posedge clk); #1;
        wb_en_i = 1'b0;
        drive(5'd6, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        #1;
        total += 2;
        if (busy_o !== 1'b1) begin bad++; $display("FAIL coll_busy: got %0b want 1", busy_o); end
        if (dec_ready_o !== 1'b0) begin bad++; $display("FAIL coll_pending6: got %0b want 0", dec_ready_o); end
        dec_valid_i = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1);
        @(posedge clk); #1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1);
        @(posedge clk); #1;
        drive(5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        ex_ready_i = 1'b0;
        #1;
        total += 2;
        if (dec_ready_o !== 1'b0) begin bad++; $display("FAIL ar_stall: got %0b want 0", dec_ready_o); end
        if (busy_o !== 1'b1) begin bad++; $display("FAIL ar_busy_before: got %0b want 1", busy_o); end
        rst_n = 1'b0;
        #1;
        total += 3;
        if (ex_valid_o !== 1'b0) begin bad++; $display("FAIL ar_valid: got %0b want 0", ex_valid_o); end
        if (busy_o !== 1'b0) begin bad++; $display("FAIL ar_busy: got %0b want 0", busy_o); end
        if (ex_rd_o !== 5'd0) begin bad++; $display("FAIL ar_rd: got %0d want 0", ex_rd_o); end
        apply_reset();
    endtask

    task automatic test_random();
        logic [XLEN:0] s1, s2;
        bit waw, exp_ready, acc;
        apply_reset();
        for (int n = 0; n < 500; n++) begin
            drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1));
            dec_valid_i = ($urandom_range(0, 3) != 0);
            ex_ready_i  = ($urandom_range(0, 9) < 7);
            wb_en_i     = ($urandom_range(0, 9) < 4);
            if (inflight.size() != 0 && $urandom_range(0, 3) != 0)
                wb_addr_i = inflight[$urandom_range(0, inflight.size() - 1)];
            else
                wb_addr_i = $urandom_range(0, 7);
            wb_data_i = $urandom;
            #1;
            s1 = ref_src(dec_use_rs1_i, dec_rs1_i);
            s2 = ref_src(dec_use_rs2_i, dec_rs2_i);
            waw = dec_rd_wr_i && dec_rd_i != 5'd0 && is_pending(dec_rd_i) &&
                  !(wb_en_i && wb_addr_i == dec_rd_i);
            exp_ready = (!m_valid || ex_ready_i) && s1[XLEN] && s2[XLEN] && !waw;
            total += 2;
            if (dec_ready_o !== exp_ready) begin
                bad++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", n, dec_ready_o, exp_ready);
            end
            if (rf_rs1_addr_o !== dec_rs1_i || rf_rs2_addr_o !== dec_rs2_i) begin
                bad++; $display("FAIL rnd_rfaddr[%0d]: got %0d/%0d want %0d/%0d", n,
                                rf_rs1_addr_o, rf_rs2_addr_o, dec_rs1_i, dec_rs2_i);
            end
            acc = dec_valid_i && exp_ready;
            if (acc) begin
                m_valid = 1'b1; m_rs1 = s1[XLEN-1:0]; m_rs2 = s2[XLEN-1:0];
                m_rd = dec_rd_i; m_rdwr = dec_rd_wr_i;
            end else if (ex_ready_i) begin
                m_valid = 1'b0;
            end
            if (wb_en_i && wb_addr_i != 5'd0)
                for (int i = inflight.size() - 1; i >= 0; i--)
                    if (inflight[i] == wb_addr_i) inflight.delete(i);
            if (acc && dec_rd_wr_i && dec_rd_i != 5'd0) inflight.push_back(dec_rd_i);
            @(posedge clk); #1;
            total += 2;
            if (ex_valid_o !== m_valid) begin
                bad++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", n, ex_valid_o, m_valid);
            end
            if (busy_o !== (inflight.size() != 0)) begin
                bad++; $display("FAIL rnd_busy[%0d]: got %0b want %0b", n, busy_o, inflight.size() != 0);
            end
            if (m_valid) begin
                total++;
                if (ex_rs1_o !== m_rs1 || ex_rs2_o !== m_rs2 || ex_rd_o !== m_rd || ex_rd_wr_o !== m_rdwr) begin
                    bad++;
                    $display("FAIL rnd_ex[%0d]: got %h %h %0d %0b want %h %h %0d %0b", n,
                             ex_rs1_o, ex_rs2_o, ex_rd_o, ex_rd_wr_o, m_rs1, m_rs2, m_rd, m_rdwr);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_raw();
        test_x0();
        test_backpressure();
        test_collision();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Read-side companion of the integer register bank; sits between decode and execute.
- Drives the bank's two read addresses and captures operands into an execute-stage pipeline register.
- Tracks in-flight destination writes with a 32-entry scoreboard and stalls decode on RAW/WAW hazards.
- Observes the same writeback bus that drives the bank's write port, to clear the scoreboard and optionally bypass.

Parameters:
- XLEN, 32, operand/data width.
- AW, 5, register address width; bank depth is 2**AW; x0 is hardwired zero.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- dec_valid_i  in  1  decode presents an instruction.
- dec_ready_o  out  1  stage accepts the instruction this cycle.
- dec_rs1_i, dec_rs2_i  in  AW  source register addresses.
- dec_use_rs1_i, dec_use_rs2_i  in  1  source actually read.
- dec_rd_i  in  AW  destination address.
- dec_rd_wr_i  in  1  instruction writes rd.
- rf_rs1_addr_o, rf_rs2_addr_o  out  AW  bank read addresses; wired straight from dec_rs1_i/dec_rs2_i.
- rf_rs1_data_i, rf_rs2_data_i  in  XLEN  bank combinational read data.
- wb_en_i  in  1  writeback strobe; same signal as the bank write enable.
- wb_addr_i  in  AW  writeback register address.
- wb_data_i  in  XLEN  writeback data.
- ex_valid_o  out  1  execute register holds a valid instruction.
- ex_ready_i  in  1  execute consumes it.
- ex_rs1_o, ex_rs2_o  out  XLEN  captured operands.
- ex_rd_o  out  AW  captured destination.
- ex_rd_wr_o  out  1  captured write flag.
- busy_o  out  1  OR of all scoreboard bits.

Behaviour:
- Reset (async, immediate): ex_valid_o=0, ex_rs1_o=0, ex_rs2_o=0, ex_rd_o=0, ex_rd_wr_o=0, scoreboard all 0, busy_o=0.
- Operand source, per used source s:
  - s==0: operand is 0, never hazarded.
  - BYPASS_EN and wb_en_i and wb_addr_i==s: operand is wb_data_i, ready.
  - Otherwise: operand is the bank data; ready only if pending[s]==0.
  - Unused sources are always ready and are captured as 0.
- WAW stall: dec_rd_wr_i && dec_rd_i!=0 && pending[dec_rd_i] && !(wb_en_i && wb_addr_i==dec_rd_i).
  - The wb clear is same-cycle, regardless of BYPASS_EN.
- hazard = any source not ready OR WAW stall.
- slot_free = !ex_valid_o || ex_ready_i.
- dec_ready_o = slot_free && !hazard. This is combinational and valid independent of dec_valid_i.
- Accept = dec_valid_i && dec_ready_o. On accept, next cycle:
  - ex_valid_o=1.
  - ex_rs1_o/ex_rs2_o/ex_rd_o/ex_rd_wr_o loaded.
  - If dec_rd_wr_i && dec_rd_i!=0, pending[dec_rd_i] is set.
- Latency: 1 cycle from accept to ex_valid_o.
- If ex_valid_o && ex_ready_i && !accept, ex_valid_o clears next cycle.
- If ex_valid_o && !ex_ready_i, the execute register holds all its values and dec_ready_o=0.
- Scoreboard clear: wb_en_i && wb_addr_i!=0 clears pending[wb_addr_i].
- Same-cycle set and clear of the same index: set wins.
- wb_en_i with wb_addr_i==0 has no effect.
- Writeback to a non-pending register: clear is harmless, no error.
- The execute register never re-reads the bank; held operands are stable even if the bank is written while stalled.
- Reset mid-operation: all pending writes are forgotten; the in-flight instruction is dropped.

Optional Feature:
- Macro: OPERAND_FETCH_BYPASS_EN.
- Defined: same-cycle forwarding of wb_data_i as described above; a dependent instruction issues in the writeback cycle.
- Undefined:
  - No forwarding; operands come only from the bank.
  - A dependent instruction stalls through the writeback cycle and issues the following cycle, once the bank has been written at the edge.
  - Scoreboard timing is unchanged.

Test Plan:
- Reset released, dec rs1=3 rs2=4 rd=5 rd_wr=1, bank x3=7 x4=9, ex_ready_i=1 -> next cycle ex_valid_o=1, ex_rs1_o=7, ex_rs2_o=9, ex_rd_o=5, pending[5]=1, busy_o=1.
- RAW: after above, dec rs1=5 -> dec_ready_o=0 until wb_en_i=1, wb_addr_i=5, wb_data_i=0x1234.
  - With BYPASS_EN: accept in that cycle, ex_rs1_o=0x1234.
  - Without: accept next cycle, ex_rs1_o=0x1234 from the bank.
- x0: dec rs1=0, rd=0, rd_wr=1, bank returns garbage -> ex_rs1_o=0, no scoreboard bit set, busy_o unchanged.
- Backpressure: ex_valid_o=1, ex_ready_i=0 for 3 cycles with a new dec_valid_i -> dec_ready_o=0, ex outputs unchanged; ex_ready_i=1 -> new instruction loaded next cycle.
- Set/clear collision: pending[6]=1; wb_en_i writes x6 while a new instruction with rd=6 is accepted -> pending[6] stays 1.
- Async reset asserted mid-stall with pending[2,7]=1 -> ex_valid_o=0 and busy_o=0 immediately, without waiting for a clock edge.
